// File: rtl/controller_poller.sv
// Polls NES/SNES-style serial game controllers in parallel: latch, shift out
// each controller's bits, then publish button state with press/release edge pulses.
module controller_poller #(
    parameter int NUM_CONTROLLERS     = 2,
    parameter int BITS_PER_CONTROLLER = 8,
    parameter int CLK_DIV             = 4,
    parameter int AUTO_POLL_CYCLES    = 16384
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          start_fetch_i,
    input  logic                                          auto_poll_en_i,
    input  logic [NUM_CONTROLLERS-1:0]                    serial_LIST_ni,
    output logic                                          latch_o,
    output logic                                          ctrl_clk_o,
    output logic                                          busy_o,
    output logic                                          valid_o,
    output logic [BITS_PER_CONTROLLER*NUM_CONTROLLERS-1:0] data_LIST_o,
    output logic [BITS_PER_CONTROLLER*NUM_CONTROLLERS-1:0] pressed_LIST_o,
    output logic [BITS_PER_CONTROLLER*NUM_CONTROLLERS-1:0] released_LIST_o
);

    localparam int B     = BITS_PER_CONTROLLER;
    localparam int W     = BITS_PER_CONTROLLER * NUM_CONTROLLERS;
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int CNT_W = $clog2(BITS_PER_CONTROLLER + 1);
    localparam int TMR_W = $clog2(AUTO_POLL_CYCLES);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] LATCH     = 2'd1;
    localparam logic [1:0] READ_LOW  = 2'd2;
    localparam logic [1:0] READ_HIGH = 2'd3;

    logic [1:0]                 state_q, state_d;
    logic [DIV_W-1:0]           div_q, div_d;
    logic                       latch_half_q, latch_half_d;
    logic [CNT_W-1:0]           bit_cnt_q, bit_cnt_d;
    logic [TMR_W-1:0]           timer_q, timer_d;
    logic [NUM_CONTROLLERS-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
    logic [W-1:0]               shift_q, shift_d;
    logic [W-1:0]               data_q, data_d;
    logic [W-1:0]               pressed_q, pressed_d;
    logic [W-1:0]               released_q, released_d;
    logic                       valid_q, valid_d;
    logic                       tick, timer_wrap, poll_req;
    logic [B:0]                 ext;

    always_comb begin
        tick       = (div_q == DIV_W'(CLK_DIV - 1));
        timer_wrap = auto_poll_en_i && (timer_q == TMR_W'(AUTO_POLL_CYCLES - 1));
        poll_req   = start_fetch_i || timer_wrap;

        if (!auto_poll_en_i || timer_wrap)
            timer_d = '0;
        else
            timer_d = timer_q + TMR_W'(1);

        // Divider only runs during a poll so every poll starts phase-aligned.
        if (state_q == IDLE || tick)
            div_d = '0;
        else
            div_d = div_q + DIV_W'(1);

        sync1_d      = serial_LIST_ni;
        sync2_d      = sync1_q;
        state_d      = state_q;
        latch_half_d = latch_half_q;
        bit_cnt_d    = bit_cnt_q;
        shift_d      = shift_q;
        data_d       = data_q;
        pressed_d    = '0;
        released_d   = '0;
        valid_d      = 1'b0;
        ext          = '0;

        case (state_q)
            IDLE: begin
                if (poll_req) begin
                    state_d      = LATCH;
                    latch_half_d = 1'b0;
                end
            end
            LATCH: begin
                if (tick) begin
                    if (latch_half_q) begin
                        state_d   = READ_LOW;
                        bit_cnt_d = CNT_W'(B);
                    end else begin
                        latch_half_d = 1'b1;
                    end
                end
            end
            READ_LOW: begin
                if (tick) begin
                    for (int c = 0; c < NUM_CONTROLLERS; c++) begin
                        ext              = {shift_q[c*B +: B], ~sync2_q[c]};
                        shift_d[c*B +: B] = ext[B-1:0];
                    end
                    bit_cnt_d = bit_cnt_q - CNT_W'(1);
                    state_d   = READ_HIGH;
                end
            end
            READ_HIGH: begin
                if (tick) begin
                    if (bit_cnt_q != '0) begin
                        state_d = READ_LOW;
                    end else begin
                        state_d    = IDLE;
                        data_d     = shift_q;
                        pressed_d  = shift_q & ~data_q;
                        released_d = ~shift_q & data_q;
                        valid_d    = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Synchronizers reset to 1 so an unplugged line reads as "released".
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            div_q        <= '0;
            latch_half_q <= 1'b0;
            bit_cnt_q    <= '0;
            timer_q      <= '0;
            sync1_q      <= '1;
            sync2_q      <= '1;
            shift_q      <= '0;
            data_q       <= '0;
            pressed_q    <= '0;
            released_q   <= '0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            div_q        <= div_d;
            latch_half_q <= latch_half_d;
            bit_cnt_q    <= bit_cnt_d;
            timer_q      <= timer_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            shift_q      <= shift_d;
            data_q       <= data_d;
            pressed_q    <= pressed_d;
            released_q   <= released_d;
            valid_q      <= valid_d;
        end
    end

    assign latch_o         = (state_q == LATCH);
    assign ctrl_clk_o      = (state_q != READ_LOW);
    assign busy_o          = (state_q != IDLE);
    assign valid_o         = valid_q;
    assign data_LIST_o     = data_q;
    assign pressed_LIST_o  = pressed_q;
    assign released_LIST_o = released_q;

endmodule

// File: tb/tb_controller_poller.sv
// Directed bench for controller_poller: default, auto-poll and 3x16-bit
// configurations, with behavioural controllers answering latch/clock.
module tb_controller_poller;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int compared   = 0;
    int mismatched = 0;

    // Instance A: defaults
    logic        rstA = 1'b1, startA = 1'b0;
    logic [1:0]  serialA = '1;
    logic        latchA, ctrlClkA, busyA, validA;
    logic [15:0] dataA, pressedA, releasedA;
    logic [7:0]  patA [2];
    int          bitA = 8;
    logic        prevClkA = 1'b1;

    controller_poller dutA (
        .clk(clock), .rst(rstA), .start_fetch_i(startA), .auto_poll_en_i(1'b0),
        .serial_LIST_ni(serialA), .latch_o(latchA), .ctrl_clk_o(ctrlClkA),
        .busy_o(busyA), .valid_o(validA), .data_LIST_o(dataA),
        .pressed_LIST_o(pressedA), .released_LIST_o(releasedA)
    );

    // Instance B: short auto-poll period
    logic        rstB = 1'b1, enB = 1'b0;
    logic        latchB, ctrlClkB, busyB, validB;
    logic [15:0] dataB, pressedB, releasedB;

    controller_poller #(.AUTO_POLL_CYCLES(100)) dutB (
        .clk(clock), .rst(rstB), .start_fetch_i(1'b0), .auto_poll_en_i(enB),
        .serial_LIST_ni(2'b11), .latch_o(latchB), .ctrl_clk_o(ctrlClkB),
        .busy_o(busyB), .valid_o(validB), .data_LIST_o(dataB),
        .pressed_LIST_o(pressedB), .released_LIST_o(releasedB)
    );

    // Instance C: three SNES-style controllers, fast divider
    logic        rstC = 1'b1, startC = 1'b0;
    logic [2:0]  serialC = '1;
    logic        latchC, ctrlClkC, busyC, validC;
    logic [47:0] dataC, pressedC, releasedC;
    logic [15:0] patC [3];
    int          bitC = 16;
    logic        prevClkC = 1'b1;

    controller_poller #(.NUM_CONTROLLERS(3), .BITS_PER_CONTROLLER(16), .CLK_DIV(3)) dutC (
        .clk(clock), .rst(rstC), .start_fetch_i(startC), .auto_poll_en_i(1'b0),
        .serial_LIST_ni(serialC), .latch_o(latchC), .ctrl_clk_o(ctrlClkC),
        .busy_o(busyC), .valid_o(validC), .data_LIST_o(dataC),
        .pressed_LIST_o(pressedC), .released_LIST_o(releasedC)
    );

    // Controllers present bit 0 while latched, then the next bit on each
    // rising shift clock; lines are active-low.
    always @(negedge clock) begin
        if (latchA) bitA = 0;
        else if (ctrlClkA && !prevClkA) bitA = bitA + 1;
        prevClkA = ctrlClkA;
        for (int c = 0; c < 2; c++)
            serialA[c] = (bitA < 8) ? ~patA[c][7-bitA] : 1'b1;
        if (latchC) bitC = 0;
        else if (ctrlClkC && !prevClkC) bitC = bitC + 1;
        prevClkC = ctrlClkC;
        for (int c = 0; c < 3; c++)
            serialC[c] = (bitC < 16) ? ~patC[c][15-bitC] : 1'b1;
    end

    // Statistics gathered over one stimulus window
    int          nLatch, nLow, nFall, nValid, nRise, firstValid;
    int          rise [4];
    logic [63:0] capData, capPressed, capReleased;
    int          found;
    int          nRiseB;
    int          riseB [4];
    logic        prevLatchB;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Drives start for instance sel (0=A, 2=C): high for the first `hold`
    // cycles and at cycles p0/p1; index k = state after the k-th edge.
    task automatic applyStimulus(input int sel, input int cycles, input int hold, input int p0, input int p1);
        logic lt, ck, vd, prevLt, prevCk;
        logic [63:0] dt, pr, rl;
        nLatch = 0; nLow = 0; nFall = 0; nValid = 0; nRise = 0; firstValid = -1;
        capData = '0; capPressed = '0; capReleased = '0;
        prevLt = (sel == 0) ? latchA : latchC;
        prevCk = (sel == 0) ? ctrlClkA : ctrlClkC;
        for (int k = 0; k < cycles; k++) begin
            if (sel == 0) startA = (k < hold) || (k == p0) || (k == p1);
            else          startC = (k < hold) || (k == p0) || (k == p1);
            @(negedge clock);
            if (sel == 0) begin
                lt = latchA; ck = ctrlClkA; vd = validA;
                dt = 64'(dataA); pr = 64'(pressedA); rl = 64'(releasedA);
            end else begin
                lt = latchC; ck = ctrlClkC; vd = validC;
                dt = 64'(dataC); pr = 64'(pressedC); rl = 64'(releasedC);
            end
            if (lt) nLatch++;
            if (lt && !prevLt) begin
                if (nRise < 4) rise[nRise] = k;
                nRise++;
            end
            if (!ck) nLow++;
            if (!ck && prevCk) nFall++;
            if (vd) begin
                if (nValid == 0) firstValid = k;
                nValid++;
                capData = dt; capPressed = pr; capReleased = rl;
            end
            prevLt = lt;
            prevCk = ck;
        end
        startA = 1'b0;
        startC = 1'b0;
    endtask

    initial begin
        patA[0] = 8'hA5; patA[1] = 8'h3C;
        patC[0] = 16'h1234; patC[1] = 16'hBEEF; patC[2] = 16'h8001;

        repeat (3) @(negedge clock);
        checkOutput("resetCtlA", 64'({latchA, ctrlClkA, busyA, validA}), 64'b0100);
        checkOutput("resetDataA", 64'({dataA, pressedA, releasedA}), 64'h0);
        rstA = 1'b0;
        @(negedge clock);

        // First poll from reset
        applyStimulus(0, 80, 1, -1, -1);
        checkOutput("poll1Latch", 64'(nLatch), 64'd8);
        checkOutput("poll1ClkLow", 64'(nLow), 64'd32);
        checkOutput("poll1ClkFalls", 64'(nFall), 64'd8);
        checkOutput("poll1ValidEdge", 64'(firstValid), 64'd72);
        checkOutput("poll1ValidCount", 64'(nValid), 64'd1);
        checkOutput("poll1Data", capData, 64'h3CA5);
        checkOutput("poll1Pressed", capPressed, 64'h3CA5);
        checkOutput("poll1Released", capReleased, 64'h0);

        // Follow-up poll: edge detection against previous publish
        patA[0] = 8'h0F;
        applyStimulus(0, 80, 1, -1, -1);
        checkOutput("poll2Data", capData, 64'h3C0F);
        checkOutput("poll2Pressed", capPressed, 64'h000A);
        checkOutput("poll2Released", capReleased, 64'h00A0);

        // Held request: back-to-back polls, 73-cycle spacing
        applyStimulus(0, 300, 200, -1, -1);
        checkOutput("holdPolls", 64'(nRise), 64'd3);
        checkOutput("holdValids", 64'(nValid), 64'd3);
        checkOutput("holdFirstRise", 64'(rise[0]), 64'd0);
        checkOutput("holdSpacing", 64'(rise[1] - rise[0]), 64'd73);
        checkOutput("holdPressed", capPressed, 64'h0);

        // Requests while busy are dropped
        applyStimulus(0, 150, 1, 30, 60);
        checkOutput("busyPolls", 64'(nRise), 64'd1);
        checkOutput("busyValids", 64'(nValid), 64'd1);

        // Async reset mid-poll
        applyStimulus(0, 20, 1, -1, -1);
        @(posedge clock);
        #2 rstA = 1'b1;
        #1;
        checkOutput("asyncRstCtl", 64'({latchA, ctrlClkA, busyA, validA}), 64'b0100);
        checkOutput("asyncRstData", 64'({dataA, pressedA, releasedA}), 64'h0);
        @(negedge clock);
        rstA = 1'b0;
        applyStimulus(0, 80, 0, -1, -1);
        checkOutput("abortNoValid", 64'(nValid), 64'd0);
        applyStimulus(0, 80, 1, -1, -1);
        checkOutput("afterRstValidEdge", 64'(firstValid), 64'd72);
        checkOutput("afterRstData", capData, 64'h3C0F);
        checkOutput("afterRstPressed", capPressed, 64'h3C0F);
        checkOutput("afterRstReleased", capReleased, 64'h0);

        // Auto poll timer
        enB = 1'b1;
        @(negedge clock);
        rstB = 1'b0;
        nRiseB = 0;
        prevLatchB = latchB;
        for (int k = 0; k < 320; k++) begin
            @(negedge clock);
            if (latchB && !prevLatchB) begin
                if (nRiseB < 4) riseB[nRiseB] = k;
                nRiseB++;
            end
            prevLatchB = latchB;
        end
        checkOutput("autoCount", 64'(nRiseB), 64'd3);
        checkOutput("autoRise0", 64'(riseB[0]), 64'd99);
        checkOutput("autoRise1", 64'(riseB[1]), 64'd199);
        checkOutput("autoRise2", 64'(riseB[2]), 64'd299);
        enB = 1'b0;
        nRiseB = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clock);
            if (latchB && !prevLatchB) nRiseB++;
            prevLatchB = latchB;
        end
        checkOutput("autoDisabled", 64'(nRiseB), 64'd0);

        // 3 x 16-bit, CLK_DIV=3
        rstC = 1'b0;
        @(negedge clock);
        applyStimulus(2, 110, 1, -1, -1);
        checkOutput("wideValidEdge", 64'(firstValid), 64'd102);
        checkOutput("wideData", capData, 64'h8001_BEEF_1234);
        checkOutput("widePressed", capPressed, 64'h8001_BEEF_1234);
        checkOutput("wideReleased", capReleased, 64'h0);

        // Reset while in READ_LOW
        applyStimulus(2, 1, 1, -1, -1);
        found = 0;
        for (int i = 0; i < 40 && found == 0; i++) begin
            @(negedge clock);
            if (!ctrlClkC) found = 1;
        end
        checkOutput("wideReachReadLow", 64'(found), 64'd1);
        rstC = 1'b1;
        #1;
        checkOutput("wideRstBusy", 64'(busyC), 64'd0);
        @(negedge clock);
        rstC = 1'b0;
        applyStimulus(2, 120, 0, -1, -1);
        checkOutput("wideAbortNoValid", 64'(nValid), 64'd0);
        patC[0] = 16'hFFFF; patC[1] = 16'h0000; patC[2] = 16'h5A5A;
        applyStimulus(2, 110, 1, -1, -1);
        checkOutput("wide2ValidEdge", 64'(firstValid), 64'd102);
        checkOutput("wide2Data", capData, 64'h5A5A_0000_FFFF);
        checkOutput("wide2Pressed", capPressed, 64'h5A5A_0000_FFFF);
        checkOutput("wide2Released", capReleased, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
